// File: rtl/vram_pkg.sv
// Shared types and sizes for the character/video RAM bridge.
package vram_pkg;

    localparam int VRAM_AW    = 12;
    localparam int VRAM_DEPTH = 1 << VRAM_AW;

    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [7:0]         data;
    } vram_wr_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FILL
    } vram_state_e;

endpackage

// File: rtl/vram_if.sv
// CPU-side and PPU-side signals of the VRAM bridge, bundled for port lists.
interface vram_if;
    import vram_pkg::*;

    logic [15:0]        cpu_addr;
    logic [7:0]         cpu_wdata;
    logic               cpu_we;
    logic [7:0]         cpu_rdata;
    logic               cpu_rdy;
    logic               de;
    logic [VRAM_AW-1:0] ppu_addr;
    logic [7:0]         ppu_data;
    logic               busy;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, de, ppu_addr,
        input  cpu_rdata, cpu_rdy, ppu_data, busy
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, de, ppu_addr,
        output cpu_rdata, cpu_rdy, ppu_data, busy
    );

endinterface

// File: rtl/vram_dp.sv
// 4096x8 dual-port RAM: port A sync read/write for the bridge, port B sync read for the PPU.
module vram_dp
    import vram_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_en,
    input  logic               a_we,
    input  logic [VRAM_AW-1:0] a_addr,
    input  logic [7:0]         a_wdata,
    output logic [7:0]         a_rdata,
    input  logic [VRAM_AW-1:0] b_addr,
    output logic [7:0]         b_rdata
);

    logic [7:0] mem [VRAM_DEPTH];

    // The array itself is never reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
        end else if (a_en && !a_we) begin
            a_rdata <= mem[a_addr];
        end
    end

    // Same-address write on port A yields the old byte here (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rdata <= '0;
        end else begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/vram_bridge.sv
// 6502-to-VRAM bridge: queues CPU writes and commits them (or a whole-RAM fill)
// during blanking, with CPU read-back and RDY stalling.
module vram_bridge
    import vram_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h1000,
    parameter logic [15:0] FILL_ADDR  = 16'h0FFF,
    parameter int          FIFO_DEPTH = 8,
    parameter bit          BLANK_ONLY = 1'b1
) (
    input logic   clk,
    input logic   rst_n,
    vram_if.slave bus
);

    localparam int PW = $clog2(FIFO_DEPTH);

    vram_state_e        state;
    vram_state_e        next_state;

    vram_wr_t           fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW:0]        count;
    vram_wr_t           head;
    vram_wr_t           entry;

    logic [VRAM_AW-1:0] fill_cnt;
    logic [7:0]         fill_val;

    logic               win;
    logic               fhit;
    logic               fifo_empty;
    logic               fifo_full;
    logic               commit_ok;
    logic               busy;
    logic               stall;
    logic               push;
    logic               pop;
    logic               fill_go;
    logic               fill_wr;
    logic               fill_last;
    logic               rd_go;

    logic               a_en;
    logic               a_we;
    logic [VRAM_AW-1:0] a_addr;
    logic [7:0]         a_wdata;
    logic [7:0]         a_rdata;
    logic [7:0]         b_rdata;

    assign win        = (bus.cpu_addr[15:12] == BASE_ADDR[15:12]);
    assign fhit       = (bus.cpu_addr == FILL_ADDR);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign commit_ok  = ~BLANK_ONLY | ~bus.de;
    assign busy       = ~fifo_empty | (state == FILL);

    assign head  = fifo_mem[rd_ptr];
    assign entry = '{addr: bus.cpu_addr[VRAM_AW-1:0], data: bus.cpu_wdata};

    // Reads wait for every queued write and any fill, so port A never has two users.
    always_comb begin
        stall = 1'b0;
        if (win && bus.cpu_we && fifo_full) begin
            stall = 1'b1;
        end
        if ((win || fhit) && (state == FILL)) begin
            stall = 1'b1;
        end
        if (win && !bus.cpu_we && busy) begin
            stall = 1'b1;
        end
        if (fhit && bus.cpu_we && !fifo_empty) begin
            stall = 1'b1;
        end
    end

    assign push      = win  &  bus.cpu_we & ~stall;
    assign fill_go   = fhit &  bus.cpu_we & ~stall;
    assign rd_go     = win  & ~bus.cpu_we & ~stall;
    assign pop       = (state == DRAIN) & commit_ok & ~fifo_empty;
    assign fill_wr   = (state == FILL) & commit_ok;
    assign fill_last = fill_wr & (fill_cnt == '1);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (fill_go) begin
                    next_state = FILL;
                end else if (!fifo_empty) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && !push && (count == (PW+1)'(1))) begin
                    next_state = IDLE;
                end
            end
            FILL: begin
                if (fill_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fill_cnt <= '0;
            fill_val <= '0;
        end else begin
            state <= next_state;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (fill_go) begin
                fill_val <= bus.cpu_wdata;
                fill_cnt <= '0;
            end else if (fill_wr) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= entry;
        end
    end

    // Commit traffic owns port A; a CPU read only gets through when nothing is pending.
    always_comb begin
        a_en    = 1'b0;
        a_we    = 1'b0;
        a_addr  = bus.cpu_addr[VRAM_AW-1:0];
        a_wdata = '0;
        if (pop) begin
            a_en    = 1'b1;
            a_we    = 1'b1;
            a_addr  = head.addr;
            a_wdata = head.data;
        end else if (fill_wr) begin
            a_en    = 1'b1;
            a_we    = 1'b1;
            a_addr  = fill_cnt;
            a_wdata = fill_val;
        end else if (rd_go) begin
            a_en    = 1'b1;
        end
    end

    vram_dp u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_en    (a_en),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .b_addr  (bus.ppu_addr),
        .b_rdata (b_rdata)
    );

    assign bus.cpu_rdata = a_rdata;
    assign bus.ppu_data  = b_rdata;
    assign bus.cpu_rdy   = ~stall;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_vram_bridge.sv
// Randomised bench for vram_bridge against a plain array model of the VRAM.
module tb_vram_bridge;
    import vram_pkg::*;

    localparam logic [15:0] BASE   = 16'h1000;
    localparam logic [15:0] FILL_A = 16'h0FFF;
    localparam int          BOUND  = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   rand_de = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model_mem [VRAM_DEPTH];

    vram_if bus();
    vram_if bus2();

    vram_bridge #(
        .BASE_ADDR  (16'h1000),
        .FILL_ADDR  (16'h0FFF),
        .FIFO_DEPTH (8),
        .BLANK_ONLY (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vram_bridge #(
        .BASE_ADDR  (16'h1000),
        .FILL_ADDR  (16'h0FFF),
        .FIFO_DEPTH (8),
        .BLANK_ONLY (1'b0)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; combinational outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_de) begin
            bus.de = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, output int stalls);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_we    = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (!bus.cpu_rdy && stalls < BOUND) begin
            tick();
            stalls++;
            @(negedge clk);
        end
        tick();
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h0000;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d, output int stalls);
        bus.cpu_addr = a;
        bus.cpu_we   = 1'b0;
        stalls = 0;
        @(negedge clk);
        while (!bus.cpu_rdy && stalls < BOUND) begin
            tick();
            stalls++;
            @(negedge clk);
        end
        tick();
        d = bus.cpu_rdata;
        bus.cpu_addr = 16'h0000;
    endtask

    task automatic ppu_read(input logic [11:0] a, output logic [7:0] d);
        bus.ppu_addr = a;
        tick();
        d = bus.ppu_data;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        rand_de = 1'b0;
        bus.de  = 1'b0;
        while (bus.busy && n < 6000) begin
            tick();
            n++;
        end
        checkOutput(tag, n < 6000, 1);
    endtask

    task automatic scan_all(input string tag);
        int bad;
        logic [7:0] d;
        bad = 0;
        for (int i = 0; i < VRAM_DEPTH; i++) begin
            ppu_read(12'(i), d);
            if (d !== model_mem[i]) bad++;
        end
        checkOutput(tag, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  d, wd, fv, rw, nd8;
        logic [11:0] wa, ra;
        logic [11:0] na [8];
        logic [7:0]  nd [8];
        logic [7:0]  bd [3];
        int st, run, viol, hi, lat, n, stall_sum;

        bus.cpu_addr  = 16'h0000; bus.cpu_wdata  = 8'h00; bus.cpu_we  = 1'b0;
        bus.de        = 1'b1;     bus.ppu_addr   = 12'h000;
        bus2.cpu_addr = 16'h0000; bus2.cpu_wdata = 8'h00; bus2.cpu_we = 1'b0;
        bus2.de       = 1'b1;     bus2.ppu_addr  = 12'h000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rdata", bus.cpu_rdata, 8'h00);
        checkOutput("rst_ppu_data", bus.ppu_data, 8'h00);
        checkOutput("rst_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_rdy", bus.cpu_rdy, 1'b1);
        tick();

        // Clear-screen fill with blanking held; a window write waits the whole fill out.
        bus.de = 1'b0;
        applyStimulus(FILL_A, 8'h20, st);
        checkOutput("fill_accept", st, 0);
        wa = 12'($urandom);
        wd = 8'($urandom);
        bus.cpu_addr  = BASE | 16'(wa);
        bus.cpu_wdata = wd;
        bus.cpu_we    = 1'b1;
        run  = 0;
        viol = 0;
        @(negedge clk);
        while (bus.busy && run < 5000) begin
            run++;
            if (bus.cpu_rdy) viol++;
            tick();
            @(negedge clk);
        end
        checkOutput("fill_busy_cycles", run, 4096);
        checkOutput("fill_window_stall", viol, 0);
        checkOutput("fill_post_rdy", bus.cpu_rdy, 1'b1);
        tick();
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h0000;
        for (int i = 0; i < VRAM_DEPTH; i++) model_mem[i] = 8'h20;
        model_mem[wa] = wd;
        wait_idle("fill_idle");
        scan_all("fill_scan");

        // Single write held off by active display, committed on the first blanking edge.
        bus.de       = 1'b1;
        bus.ppu_addr = 12'h005;
        applyStimulus(16'h1005, 8'h41, st);
        checkOutput("t1_accept", st, 0);
        repeat (100) tick();
        @(negedge clk);
        checkOutput("t1_hold_ppu", bus.ppu_data, model_mem[5]);
        checkOutput("t1_hold_busy", bus.busy, 1'b1);
        tick();
        bus.de = 1'b0;
        @(negedge clk);
        checkOutput("t1_blank_first", bus.ppu_data, model_mem[5]);
        tick();
        @(negedge clk);
        checkOutput("t1_old_on_write", bus.ppu_data, model_mem[5]);
        checkOutput("t1_busy_drop", bus.busy, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("t1_new", bus.ppu_data, 8'h41);
        model_mem[5] = 8'h41;
        tick();

        // Nine writes during display: the ninth sees a full queue.
        bus.de = 1'b1;
        stall_sum = 0;
        for (int i = 0; i < 8; i++) begin
            na[i] = 12'($urandom);
            nd[i] = 8'($urandom);
            applyStimulus(BASE | 16'(na[i]), nd[i], st);
            stall_sum += st;
        end
        checkOutput("nine_first8_stall", stall_sum, 0);
        nd8 = ~nd[0];
        bus.cpu_addr  = BASE | 16'(na[0]);
        bus.cpu_wdata = nd8;
        bus.cpu_we    = 1'b1;
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.cpu_rdy) hi++;
            tick();
        end
        checkOutput("nine_full_stall", hi, 0);
        bus.de = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.cpu_rdy && lat < 20) begin
            tick();
            lat++;
            @(negedge clk);
        end
        checkOutput("nine_rdy_rise", lat <= 1, 1);
        tick();
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h0000;
        for (int i = 0; i < 8; i++) model_mem[na[i]] = nd[i];
        model_mem[na[0]] = nd8;
        wait_idle("nine_idle");
        for (int i = 0; i < 8; i++) begin
            ppu_read(na[i], d);
            checkOutput("nine_data", d, model_mem[na[i]]);
        end

        // Read-after-write waits for the queued byte to land.
        bus.de = 1'b0;
        applyStimulus(16'h1010, 8'h55, st);
        cpu_read(16'h1010, d, st);
        checkOutput("wr_rd_stall", st, 2);
        checkOutput("wr_rd_data", d, 8'h55);
        model_mem[12'h010] = 8'h55;

        // Random reads/writes over a small address set with random display enable.
        rand_de = 1'b1;
        for (int k = 0; k < 80; k++) begin
            ra = 12'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) begin
                rw = 8'($urandom);
                applyStimulus(BASE | 16'(ra), rw, st);
                checkOutput("rnd_wr_bound", st < BOUND, 1);
                if (st < BOUND) model_mem[ra] = rw;
            end else begin
                cpu_read(BASE | 16'(ra), d, st);
                checkOutput("rnd_rd_bound", st < BOUND, 1);
                checkOutput("rnd_rd_data", d, model_mem[ra]);
            end
        end
        wait_idle("rnd_idle");
        for (int i = 0; i < 32; i++) begin
            ppu_read(12'(i), d);
            checkOutput("rnd_ppu", d, model_mem[i]);
        end

        // Reset in the middle of a fill leaves exactly the first 2000 bytes filled.
        fv = 8'($urandom);
        if (fv == 8'h20) fv = 8'h5A;
        bus.de = 1'b0;
        applyStimulus(FILL_A, fv, st);
        checkOutput("rf_accept", st, 0);
        repeat (2000) tick();
        checkOutput("rf_busy_mid", bus.busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rf_rst_busy", bus.busy, 1'b0);
        checkOutput("rf_rst_ppu", bus.ppu_data, 8'h00);
        checkOutput("rf_rst_rdata", bus.cpu_rdata, 8'h00);
        tick();
        rst_n = 1'b1;
        bus.cpu_addr = BASE | 16'h0123;
        bus.cpu_we   = 1'b0;
        @(negedge clk);
        checkOutput("rf_rdy", bus.cpu_rdy, 1'b1);
        checkOutput("rf_busy", bus.busy, 1'b0);
        tick();
        bus.cpu_addr = 16'h0000;
        for (int i = 0; i < 2000; i++) model_mem[i] = fv;
        scan_all("rf_scan");

        // Commit-any-cycle instance: fill during display, then three back-to-back writes.
        bus2.cpu_addr  = FILL_A;
        bus2.cpu_wdata = 8'h00;
        bus2.cpu_we    = 1'b1;
        @(negedge clk);
        checkOutput("b0_fill_rdy", bus2.cpu_rdy, 1'b1);
        tick();
        bus2.cpu_we   = 1'b0;
        bus2.cpu_addr = 16'h0000;
        n = 0;
        while (bus2.busy && n < 6000) begin
            tick();
            n++;
        end
        checkOutput("b0_fill_cycles", n, 4096);
        for (int i = 0; i < 3; i++) begin
            bd[i] = 8'($urandom_range(1, 255));
            bus2.cpu_addr  = BASE | 16'(12'h100 + 12'(i));
            bus2.cpu_wdata = bd[i];
            bus2.cpu_we    = 1'b1;
            if (i == 2) bus2.ppu_addr = 12'h100;
            @(negedge clk);
            checkOutput("b0_push_rdy", bus2.cpu_rdy, 1'b1);
            tick();
        end
        bus2.cpu_we   = 1'b0;
        bus2.cpu_addr = 16'h0000;
        @(negedge clk);
        checkOutput("b0_old_on_commit", bus2.ppu_data, 8'h00);
        tick();
        bus2.ppu_addr = 12'h101;
        @(negedge clk);
        checkOutput("b0_commit0", bus2.ppu_data, bd[0]);
        checkOutput("b0_busy_mid", bus2.busy, 1'b1);
        tick();
        bus2.ppu_addr = 12'h102;
        @(negedge clk);
        checkOutput("b0_commit1", bus2.ppu_data, bd[1]);
        checkOutput("b0_busy_done", bus2.busy, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("b0_commit2", bus2.ppu_data, bd[2]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
